// File: rtl/array_sort_check_pkg.sv
// Shared types for the array-sort-check arbiter: FSM state encoding and requester ids.
package array_sort_check_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLaunch  = 3'd1,
    StWait    = 3'd2,
    StAbort   = 3'd3,
    StRespond = 3'd4
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // The requester favoured after serving `id`.
  function automatic logic other_req(input logic id);
    return (id == REQ0) ? REQ1 : REQ0;
  endfunction

endpackage

// File: rtl/array_sort_check_rr_pick.sv
// Combinational 2-way round-robin selector; the pointer breaks ties.
module array_sort_check_rr_pick
  import array_sort_check_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic valid,
  output logic id
);

  always_comb begin
    valid = req0 | req1;
    id    = REQ0;
    if (req0 && req1) begin
      id = ptr;
    end else if (req1) begin
      id = REQ1;
    end
  end

endmodule

// File: rtl/array_sort_check_arbiter.sv
// Shares one array-sort-check unit between two requesters, round-robin, with a
// watchdog that aborts and clears a check that never completes.
module array_sort_check_arbiter
  import array_sort_check_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 32,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] array0,
  input  logic [ADDR_WIDTH-1:0] array1,
  input  logic [LEN_WIDTH-1:0]  length0,
  input  logic [LEN_WIDTH-1:0]  length1,
  output logic                  grant0,
  output logic                  grant1,
  output logic                  ack0,
  output logic                  ack1,
  output logic                  result_sorted,
  output logic                  result_error,
  output logic                  busy,
  output logic                  check_go,
  output logic [ADDR_WIDTH-1:0] check_array,
  output logic [LEN_WIDTH-1:0]  check_length,
  output logic                  check_clear,
  input  logic                  check_done,
  input  logic                  check_sorted
);

  localparam int unsigned CntWidth = $clog2(TIMEOUT);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT - 1);

  state_e              state_q;
  logic                id_q;
  logic                ptr_q;
  logic [CntWidth-1:0] cnt_q;

  logic                  pick_valid;
  logic                  pick_id;
  logic [ADDR_WIDTH-1:0] sel_array;
  logic [LEN_WIDTH-1:0]  sel_length;

  array_sort_check_rr_pick u_pick (
    .req0  (req0),
    .req1  (req1),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .id    (pick_id)
  );

  assign sel_array  = (pick_id == REQ1) ? array1 : array0;
  assign sel_length = (pick_id == REQ1) ? length1 : length0;

  // All outputs are flops loaded on the transition into the state that owns them,
  // so each pulse lines up exactly with its state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= StIdle;
      id_q          <= REQ0;
      ptr_q         <= REQ0;
      cnt_q         <= '0;
      grant0        <= 1'b0;
      grant1        <= 1'b0;
      ack0          <= 1'b0;
      ack1          <= 1'b0;
      result_sorted <= 1'b0;
      result_error  <= 1'b0;
      busy          <= 1'b0;
      check_go      <= 1'b0;
      check_clear   <= 1'b0;
      check_array   <= '0;
      check_length  <= '0;
    end else begin
      grant0      <= 1'b0;
      grant1      <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      check_go    <= 1'b0;
      check_clear <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            state_q      <= StLaunch;
            id_q         <= pick_id;
            check_array  <= sel_array;
            check_length <= sel_length;
            grant0       <= (pick_id == REQ0);
            grant1       <= (pick_id == REQ1);
            check_go     <= 1'b1;
            busy         <= 1'b1;
          end
        end
        StLaunch: begin
          state_q <= StWait;
          cnt_q   <= '0;
        end
        StWait: begin
          // A done arriving on the last watchdog cycle still wins over the abort.
          if (check_done) begin
            state_q       <= StRespond;
            result_sorted <= check_sorted;
            result_error  <= 1'b0;
            ack0          <= (id_q == REQ0);
            ack1          <= (id_q == REQ1);
          end else if (cnt_q == CntLast) begin
            state_q       <= StAbort;
            result_sorted <= 1'b0;
            result_error  <= 1'b1;
            check_clear   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntWidth'(1);
          end
        end
        StAbort: begin
          state_q <= StRespond;
          ack0    <= (id_q == REQ0);
          ack1    <= (id_q == REQ1);
        end
        StRespond: begin
          state_q <= StIdle;
          ptr_q   <= other_req(id_q);
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
